// File: rtl/mul4_seq_if.sv
// Handshake bundle for the 4x4 sequential multiplier: request side (start, a, b)
// and result side (busy, done, p).
interface mul4_seq_if;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] p;

   modport master (output start, a, b, input busy, done, p);
   modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier using one rca4 per iteration;
// 8-bit product is presented four cycles after an accepted start.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// ADD   | one shift-and-add iteration per cycle, cnt 0..3
// DONE  | done pulse, p valid; start here reloads (back-to-back)

module rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [4:0] c;

   assign c[0] = cin;
   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_bit
         assign s[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   endgenerate
   assign cout = c[4];
endmodule

module mul4_seq (
   input  logic       clk,
   input  logic       rst,
   mul4_seq_if.slave  bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state;
   logic [3:0] m;
   logic [3:0] acc;
   logic [3:0] q;
   logic [1:0] cnt;
   logic [7:0] p_r;

   logic [3:0] addend;
   logic [3:0] sum;
   logic       cout;
   logic [7:0] next_pp;
   logic       accept;

   assign addend  = q[0] ? m : 4'd0;
   assign next_pp = {cout, sum, q[3:1]};
   // start is honoured only outside ADD, so an in-flight product is never disturbed
   assign accept  = bus.start && (state == ST_IDLE || state == ST_DONE);

   rca4 u_add (
      .a    (acc),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         m     <= 4'd0;
         acc   <= 4'd0;
         q     <= 4'd0;
         cnt   <= 2'd0;
         p_r   <= 8'd0;
      end else begin
         case (state)
            ST_ADD: begin
               acc <= next_pp[7:4];
               q   <= next_pp[3:0];
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state <= ST_DONE;
                  p_r   <= next_pp;
               end
            end
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  m     <= bus.a;
                  q     <= bus.b;
                  acc   <= 4'd0;
                  cnt   <= 2'd0;
                  state <= ST_ADD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == ST_ADD);
   assign bus.done = (state == ST_DONE);
   assign bus.p    = p_r;
endmodule

// File: doc/mul4_seq.md
# mul4_seq

Sequential 4x4 unsigned shift-and-add multiplier built around one instance of the team's 4-bit ripple-carry adder `rca4`. The block feeds `rca4` with the partial-product accumulator and multiplicand each cycle and consumes its sum and carry-out. It produces an 8-bit product four cycles after a start pulse. It is the first clocked datapath stage layered on the combinational adder library.

## Interface
- Parameters: none. Width is fixed at 4x4 -> 8 by the `rca4` instance.
- `clk  input  1  rising-edge clock; single clock domain`
- `rst  input  1  asynchronous, active-high reset`
- `start  input  1  request; sampled on rising edge of clk; accepted only in IDLE or DONE`
- `a  input  4  multiplicand; captured when start is accepted`
- `b  input  4  multiplier; captured when start is accepted`
- `busy  output  1  high while in ADD state`
- `done  output  1  one-cycle pulse; p is valid from this cycle`
- `p  output  8  product; holds until the next result or reset`

## Operation
- Internal registers:
  - `m[3:0]`: multiplicand
  - `acc[3:0]`: high partial product
  - `q[3:0]`: multiplier / low partial product
  - `cnt[1:0]`
  - state
- States:
  - IDLE: start=1 -> load `m=a`, `q=b`, `acc=0`, `cnt=0`; go to ADD.
  - ADD: each cycle, one iteration; when `cnt==3`, go to DONE after that iteration.
  - DONE: `done=1`, `p={acc,q}` registered. start=1 -> load and go to ADD (back-to-back). Otherwise go to IDLE.
- `rca4` hookup:
  - operands: `a0..a3 = acc`, `b0..b3 = q[0] ? m : 0`, `cin = 0`.
  - outputs: `{cout, s3..s0}` forms a 5-bit sum.
- Iteration: `{acc, q} <= {cout, s3..s0, q[3:1]}`, i.e. the 9-bit value `{cout, sum, q}` shifted right by 1. Then `cnt <= cnt + 1`, wrapping 3 -> 0.
- Arithmetic: unsigned only. Max product 15*15 = 225 = 0xE1 fits in 8 bits, so no overflow is possible.
- start while in ADD: ignored. Operands and iteration are unaffected. No error flag.
- a and b may change freely except on the accepting edge.
- `p` updates only on entry to DONE. It is not disturbed by later loads until the next DONE.
- Reset (asserted anytime, including mid-ADD):
  - immediately forces state=IDLE and busy=0, done=0, p=0x00.
  - m, acc, q, cnt all clear to 0.
  - the in-flight operation is discarded.
- First accepted start after reset deassertion behaves normally.

## Timing
- Reset values: busy=0, done=0, p=0x00.
- Outputs are registered; no combinational path from start, a or b to any output.
- Edge sequence for an accepted start at edge E0:
  - E0 -> ADD. busy=1 during cycles after E0..E3.
  - E1..E4 perform iterations 0..3.
  - E4 -> DONE. busy=0 and done=1 in the cycle after E4, with p valid.
- Latency: done asserts 4 cycles after the accepting edge.
- Throughput: one product per 5 cycles, or per 4 cycles + DONE overlap when start is held in DONE.
- done is high for exactly one cycle unless back-to-back. On a back-to-back start accepted in DONE, the next done occurs 4 cycles later.
- Reset deassertion is treated as synchronous to clk by the bench. The first edge after release may accept start.

## Test plan
- Reset, then a=0x3, b=0x5 with start for 1 cycle -> busy high 4 cycles; done pulses 4 cycles after start; p=0x0F.
- a=0xF, b=0xF -> p=0xE1. Check that the rca4 cout path is exercised in iterations 1-3.
- a=0x7, b=0x9, then start re-pulsed with a=0x1, b=0x1 during ADD -> request ignored; p=0x3F; no extra done.
- Back-to-back: 0x2*0x6, then start held in the DONE cycle with 0xA*0x0 -> done pulses give p=0x0C, then p=0x00 4 cycles later; busy low only in DONE cycles.
- Assert rst during the 2nd ADD cycle of 0xB*0xD -> busy, done and p drop to 0 immediately, asynchronously. After release, 0x4*0x4 -> p=0x10 with normal latency.
- Exhaustive random-order sweep of all 256 a,b pairs against the a*b reference model -> every p matches; done count = 256.
